// File: rtl/fault_mem_cfg.sv
// ---------------------------------------------------------------------------
// fault_mem_cfg
// Behavioural faulty-memory model for exercising a memory BIST controller.
// One parametrised word array plus a run-time programmable fault table of
// NUM_FAULTS entries. Each entry names a victim cell/bit and a fault type:
// stuck-at, transition, coupling (inversion / idempotent) or a static
// neighbourhood-pattern-sensitive fault.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   write_read : 1 = write, 0 = read (for the address on the same cycle)
//   address    : word address; addresses >= CAPACITY are ignored
//   wdata      : write data, presented one cycle ahead of its write cycle
//   rdata      : read data, two clocks after the read address cycle
//   cfg_we     : fault table entry write strobe
//   cfg_idx    : entry index; indices >= NUM_FAULTS are ignored
//   cfg_type   : 0 none, 1 SA0, 2 SA1, 3 TF-up, 4 TF-down, 5 CFin, 6 CFid,
//                7 NPSF
//   cfg_vaddr  : victim address
//   cfg_vbit   : victim bit
//   cfg_aaddr  : aggressor address (coupling types only)
//   cfg_abit   : aggressor bit (coupling types only)
//   fault_hit  : registered pulse, the previous operation was altered
// ---------------------------------------------------------------------------
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int NUM_FAULTS = 2,
  parameter int IDX_WIDTH  = 1,
  parameter int BIT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  cfg_we,
  input  logic [IDX_WIDTH-1:0]  cfg_idx,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_vaddr,
  input  logic [BIT_WIDTH-1:0]  cfg_vbit,
  input  logic [ADDR_WIDTH-1:0] cfg_aaddr,
  input  logic [BIT_WIDTH-1:0]  cfg_abit,
  output logic                  fault_hit
);

  typedef enum logic [2:0] {
    FT_NONE = 3'd0,
    FT_SA0  = 3'd1,
    FT_SA1  = 3'd2,
    FT_TFUP = 3'd3,
    FT_TFDN = 3'd4,
    FT_CFIN = 3'd5,
    FT_CFID = 3'd6,
    FT_NPSF = 3'd7
  } fault_type_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  // Word address lies inside the populated array.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < CAPACITY);
  endfunction

  // Fault table, packed so the whole table clears in one assignment.
  logic [NUM_FAULTS-1:0][2:0]            type_q;
  logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0] vaddr_q;
  logic [NUM_FAULTS-1:0][BIT_WIDTH-1:0]  vbit_q;
  logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0] aaddr_q;
  logic [NUM_FAULTS-1:0][BIT_WIDTH-1:0]  abit_q;

  // Faulty array and the fault-free shadow used to judge read alteration.
  logic [DATA_WIDTH-1:0] mem_q    [CAPACITY];
  logic [DATA_WIDTH-1:0] mem_d    [CAPACITY];
  logic [DATA_WIDTH-1:0] golden_q [CAPACITY];
  logic [DATA_WIDTH-1:0] golden_d [CAPACITY];

  logic [DATA_WIDTH-1:0] wdata1_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [DATA_WIDTH-1:0] rdata1_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  fault_hit_q;
  logic                  fault_hit_d;

  logic                  wr_op_s;
  logic                  rd_op_s;
  logic [DATA_WIDTH-1:0] stored_s;
  logic [DATA_WIDTH-1:0] wr_eff_s;
  logic [DATA_WIDTH-1:0] rd_eff_s;
  logic                  wr_hit_s;

  logic [NUM_FAULTS-1:0]                 cf_fire_s;
  logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0] cf_addr_s;
  logic [NUM_FAULTS-1:0][BIT_WIDTH-1:0]  cf_bit_s;
  logic [NUM_FAULTS-1:0]                 cf_val_s;

  assign rdata     = rdata_q;
  assign fault_hit = fault_hit_q;

  // Fault evaluation: effective write word, coupling side effects, read word.
  always_comb begin
    logic                  v_match;
    logic                  a_match;
    logic                  a_toggle;
    logic [BIT_WIDTH-1:0]  v;
    logic [ADDR_WIDTH-1:0] nb_up;
    logic [ADDR_WIDTH-1:0] nb_dn;

    wr_op_s   = write_read && addr_in_range(address) && !rst;
    rd_op_s   = !write_read && addr_in_range(address) && !rst;
    stored_s  = mem_q[address];
    wr_eff_s  = wdata1_q;
    rd_eff_s  = stored_s;
    cf_fire_s = '0;
    cf_addr_s = vaddr_q;
    cf_bit_s  = vbit_q;
    cf_val_s  = '0;

    // Ascending order: a later entry on the same bit overrides earlier ones.
    for (int i = 0; i < NUM_FAULTS; i++) begin
      v        = vbit_q[i];
      v_match  = (vaddr_q[i] == address);
      // Aggressor equal to victim makes the coupling entry inert.
      a_match  = (aaddr_q[i] == address) && (aaddr_q[i] != vaddr_q[i]) &&
                 addr_in_range(vaddr_q[i]);
      a_toggle = (stored_s[abit_q[i]] != wdata1_q[abit_q[i]]);
      // Neighbours wrap around the populated array, not the address space.
      nb_up    = (vaddr_q[i] == LAST_ADDR) ? '0 : (vaddr_q[i] + ONE_ADDR);
      nb_dn    = (vaddr_q[i] == '0) ? LAST_ADDR : (vaddr_q[i] - ONE_ADDR);

      case (fault_type_e'(type_q[i]))
        FT_SA0: begin
          wr_eff_s[v] = v_match ? 1'b0 : wr_eff_s[v];
          rd_eff_s[v] = v_match ? 1'b0 : rd_eff_s[v];
        end
        FT_SA1: begin
          wr_eff_s[v] = v_match ? 1'b1 : wr_eff_s[v];
          rd_eff_s[v] = v_match ? 1'b1 : rd_eff_s[v];
        end
        FT_TFUP: begin
          wr_eff_s[v] = (v_match && !stored_s[v] && wdata1_q[v]) ? 1'b0 : wr_eff_s[v];
        end
        FT_TFDN: begin
          wr_eff_s[v] = (v_match && stored_s[v] && !wdata1_q[v]) ? 1'b1 : wr_eff_s[v];
        end
        FT_CFIN: begin
          cf_fire_s[i] = wr_op_s && a_match && a_toggle;
          cf_val_s[i]  = ~mem_q[vaddr_q[i]][vbit_q[i]];
        end
        FT_CFID: begin
          cf_fire_s[i] = wr_op_s && a_match && a_toggle;
          cf_val_s[i]  = wdata1_q[abit_q[i]];
        end
        FT_NPSF: begin
          wr_eff_s[v] = (v_match && mem_q[nb_up][v] && !mem_q[nb_dn][v]) ? 1'b0 : wr_eff_s[v];
        end
        default: begin
          cf_fire_s[i] = 1'b0;
        end
      endcase
    end

    // Next array state: the addressed word, then any coupled victim bits.
    mem_d    = mem_q;
    golden_d = golden_q;
    mem_d[address]    = wr_op_s ? wr_eff_s : mem_d[address];
    golden_d[address] = wr_op_s ? wdata1_q : golden_d[address];
    wr_hit_s = (wr_eff_s != wdata1_q);
    for (int i = 0; i < NUM_FAULTS; i++) begin
      wr_hit_s = wr_hit_s ||
                 (cf_fire_s[i] && (cf_val_s[i] != mem_q[cf_addr_s[i]][cf_bit_s[i]]));
      mem_d[cf_addr_s[i]][cf_bit_s[i]] =
        cf_fire_s[i] ? cf_val_s[i] : mem_d[cf_addr_s[i]][cf_bit_s[i]];
    end

    rdata1_d    = rd_op_s ? rd_eff_s : rdata1_q;
    fault_hit_d = wr_op_s ? wr_hit_s :
                  (rd_op_s ? (rd_eff_s != golden_q[address]) : 1'b0);
  end

  // Pipeline registers and fault table.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata1_q    <= '0;
      rdata1_q    <= '0;
      rdata_q     <= '0;
      fault_hit_q <= 1'b0;
      type_q      <= '0;
    end else begin
      wdata1_q    <= wdata;
      rdata1_q    <= rdata1_d;
      rdata_q     <= rdata1_q;
      fault_hit_q <= fault_hit_d;
      if (cfg_we && (32'(cfg_idx) < NUM_FAULTS)) begin
        type_q[cfg_idx]  <= cfg_type;
        vaddr_q[cfg_idx] <= cfg_vaddr;
        vbit_q[cfg_idx]  <= cfg_vbit;
        aaddr_q[cfg_idx] <= cfg_aaddr;
        abit_q[cfg_idx]  <= cfg_abit;
      end
    end
  end

  // Array contents survive reset; mem_d already drops ops in the reset cycle.
  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    golden_q <= golden_d;
  end

endmodule

// File: tb/tb_fault_mem_cfg.sv
// ---------------------------------------------------------------------------
// tb_fault_mem_cfg
// Directed bench for fault_mem_cfg. Expected read data goes into a queue when
// a read is issued and is popped when rdata becomes valid two clocks later.
// ---------------------------------------------------------------------------
module tb_fault_mem_cfg;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CAP = 16;
  localparam int NF = 2;
  localparam int IW = 1;
  localparam int BW = 3;
  localparam logic [AW-1:0] IDLE_ADDR = 4'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [2:0]    cfg_type;
  logic [AW-1:0] cfg_vaddr;
  logic [BW-1:0] cfg_vbit;
  logic [AW-1:0] cfg_aaddr;
  logic [BW-1:0] cfg_abit;
  logic          fault_hit;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  fault_mem_cfg #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP),
    .NUM_FAULTS(NF), .IDX_WIDTH(IW), .BIT_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .write_read(write_read), .address(address),
    .wdata(wdata), .rdata(rdata), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_type(cfg_type), .cfg_vaddr(cfg_vaddr), .cfg_vbit(cfg_vbit),
    .cfg_aaddr(cfg_aaddr), .cfg_abit(cfg_abit), .fault_hit(fault_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_entry(input logic [IW-1:0] idx, input logic [2:0] typ,
                           input logic [AW-1:0] va, input logic [BW-1:0] vb,
                           input logic [AW-1:0] aa, input logic [BW-1:0] ab);
    cfg_we = 1'b1; cfg_idx = idx; cfg_type = typ;
    cfg_vaddr = va; cfg_vbit = vb; cfg_aaddr = aa; cfg_abit = ab;
    tick();
    cfg_we = 1'b0;
  endtask

  // wdata one cycle ahead, then the write cycle; fault_hit reflects the write.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic exp_hit, input string tag);
    wdata = d; write_read = 1'b0; address = IDLE_ADDR;
    tick();
    write_read = 1'b1; address = a;
    tick();
    write_read = 1'b0; address = IDLE_ADDR;
    check({tag, "_hit"}, {7'd0, fault_hit}, {7'd0, exp_hit});
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                         input logic exp_hit, input string tag);
    write_read = 1'b0; address = a;
    exp_q.push_back(exp_d);
    tick();
    check({tag, "_hit"}, {7'd0, fault_hit}, {7'd0, exp_hit});
    address = IDLE_ADDR;
    tick();
    check(tag, rdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; write_read = 1'b0; address = IDLE_ADDR; wdata = 8'h00;
    cfg_we = 1'b0; cfg_idx = 1'b0; cfg_type = 3'd0; cfg_vaddr = 4'd0;
    cfg_vbit = 3'd0; cfg_aaddr = 4'd0; cfg_abit = 3'd0;
    tick();
    tick();
    check("rst_rdata", rdata, 8'h00);
    check("rst_hit", {7'd0, fault_hit}, 8'h00);
    rst = 1'b0;

    // Fault-free write / read
    do_write(4'd3, 8'hA5, 1'b0, "plain_w");
    do_read(4'd3, 8'hA5, 1'b0, "plain_r");

    // Stuck-at-1 on addr 5 bit 2
    set_entry(1'b0, 3'd2, 4'd5, 3'd2, 4'd0, 3'd0);
    do_write(4'd5, 8'h00, 1'b1, "sa1_w");
    do_read(4'd5, 8'h04, 1'b1, "sa1_r");

    // Transition-up on addr 2 bit 0, then removed
    set_entry(1'b0, 3'd3, 4'd2, 3'd0, 4'd0, 3'd0);
    do_write(4'd2, 8'h00, 1'b0, "tfu_w0");
    do_write(4'd2, 8'h01, 1'b1, "tfu_w1");
    do_read(4'd2, 8'h00, 1'b1, "tfu_r");
    set_entry(1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 3'd0);
    do_write(4'd2, 8'h01, 1'b0, "tfu_off_w");
    do_read(4'd2, 8'h01, 1'b0, "tfu_off_r");

    // Inversion coupling: aggressor addr 1 bit 7, victim addr 9 bit 3
    do_write(4'd1, 8'h00, 1'b0, "cf_pre_w");
    set_entry(1'b1, 3'd5, 4'd9, 3'd3, 4'd1, 3'd7);
    do_write(4'd9, 8'h00, 1'b0, "cfin_v_w");
    do_write(4'd1, 8'h80, 1'b1, "cfin_a_w");
    do_read(4'd9, 8'h08, 1'b1, "cfin_r");
    do_write(4'd1, 8'h80, 1'b0, "cfin_a_w2");
    do_read(4'd9, 8'h08, 1'b1, "cfin_r2");
    set_entry(1'b1, 3'd0, 4'd0, 3'd0, 4'd0, 3'd0);

    // NPSF on addr 0 bit 5, neighbours addr 1 and addr CAP-1 (wrap)
    set_entry(1'b0, 3'd7, 4'd0, 3'd5, 4'd0, 3'd0);
    do_write(4'd1, 8'h20, 1'b0, "npsf_up_w");
    do_write(4'(CAP - 1), 8'h00, 1'b0, "npsf_dn_w");
    do_write(4'd0, 8'hFF, 1'b1, "npsf_w");
    do_read(4'd0, 8'hDF, 1'b1, "npsf_r");
    do_write(4'(CAP - 1), 8'h20, 1'b0, "npsf_dn_w2");
    do_write(4'd0, 8'hFF, 1'b0, "npsf_w2");
    do_read(4'd0, 8'hFF, 1'b0, "npsf_r2");

    // Config write in the same cycle as a memory write uses the old table
    set_entry(1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 3'd0);
    do_write(4'd6, 8'hFF, 1'b0, "cfgsame_pre_w");
    wdata = 8'h00; write_read = 1'b0; address = IDLE_ADDR;
    tick();
    write_read = 1'b1; address = 4'd6;
    cfg_we = 1'b1; cfg_idx = 1'b0; cfg_type = 3'd4;
    cfg_vaddr = 4'd6; cfg_vbit = 3'd0; cfg_aaddr = 4'd0; cfg_abit = 3'd0;
    tick();
    cfg_we = 1'b0; write_read = 1'b0; address = IDLE_ADDR;
    check("cfgsame_hit", {7'd0, fault_hit}, 8'h00);
    do_read(4'd6, 8'h00, 1'b0, "cfgsame_r");
    do_write(4'd6, 8'h01, 1'b0, "tfd_w1");
    do_write(4'd6, 8'h00, 1'b1, "tfd_w0");
    do_read(4'd6, 8'h01, 1'b1, "tfd_r");

    // Reset in the middle of a read
    set_entry(1'b1, 3'd2, 4'd7, 3'd1, 4'd0, 3'd0);
    do_write(4'd7, 8'h00, 1'b1, "sa1b_w");
    write_read = 1'b0; address = 4'd7;
    exp_q.push_back(8'h00);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_rdata", rdata, exp_q.pop_front());
    check("midrst_hit", {7'd0, fault_hit}, 8'h00);
    rst = 1'b0; address = IDLE_ADDR;
    exp_q.push_back(8'h00);
    tick();
    check("midrst_rdata1", rdata, exp_q.pop_front());
    do_write(4'd7, 8'h00, 1'b0, "postrst_w7");
    do_read(4'd7, 8'h00, 1'b0, "postrst_r7");
    do_write(4'd6, 8'h00, 1'b0, "postrst_w6");
    do_read(4'd6, 8'h00, 1'b0, "postrst_r6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
